// File: rtl/chip8_pkg.sv
// chip8_pkg: shared constants and types for the CHIP-8 front end.
//   CHIP8_ADDR_W / CHIP8_RESET_PC : default program address width and boot pc
//   OP_*                          : opcode high-nibble field values
//   fetch_state_t                 : fetch sequencer states
//   op_field()                    : extracts the opcode class nibble
package chip8_pkg;

    localparam int unsigned CHIP8_ADDR_W   = 12;
    localparam int unsigned CHIP8_RESET_PC = 'h100;

    localparam logic [3:0] OP_SYS  = 4'h0;
    localparam logic [3:0] OP_JP   = 4'h1;
    localparam logic [3:0] OP_CALL = 4'h2;
    localparam logic [3:0] OP_SE   = 4'h3;
    localparam logic [3:0] OP_SNE  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } fetch_state_t;

    function automatic logic [3:0] op_field(input logic [15:0] op);
        return op[15:12];
    endfunction

endpackage

// File: rtl/chip8_instr_fifo.sv
// chip8_instr_fifo: small prefetch queue of {pc, opcode} entries.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous clear (wins over push)
//   push, push_instr/pc   : enqueue one entry
//   pop                   : dequeue the head (ignored when empty)
//   count                 : current occupancy
//   head_instr/pc/valid   : head entry, taken straight from register slot 0
module chip8_instr_fifo #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [15:0]       push_instr,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [15:0]       head_instr,
    output logic [ADDR_W-1:0] head_pc,
    output logic              head_valid
);

    localparam int unsigned ENTRY_W = ADDR_W + 16;

    logic [ENTRY_W-1:0] data [DEPTH];
    logic               pop_ok;
    logic               push_ok;
    int unsigned        wr_idx;

    // Shift-down organisation keeps the head in slot 0, so head outputs are
    // plain register outputs with no read mux.
    always_comb begin
        pop_ok  = pop && (count != '0);
        wr_idx  = 32'(count) - (pop_ok ? 32'd1 : 32'd0);
        push_ok = push && (wr_idx < DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (pop_ok) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    data[i] <= data[i+1];
                end
            end
            if (push_ok) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (i == wr_idx) begin
                        data[i] <= {push_pc, push_instr};
                    end
                end
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign head_instr = data[0][15:0];
    assign head_pc    = data[0][ENTRY_W-1:16];
    assign head_valid = (count != '0);

endmodule

// File: rtl/chip8_fetch.sv
// chip8_fetch: CHIP-8 instruction fetch stage.
//   clk, rst_n              : clock, asynchronous active-low reset
//   mem_rd, mem_addr        : RAM byte read request
//   mem_data                : RAM read data, one cycle after mem_rd
//   instr, instr_pc         : FIFO head opcode and its address
//   instr_valid/instr_ready : head handshake, pop = valid & ready
//   redirect, redirect_pc   : flush queue and restart fetch at redirect_pc
//   halt                    : stop starting new instructions
//   fetch_pc                : debug view of the fetch address register
module chip8_fetch
    import chip8_pkg::*;
#(
    parameter int unsigned ADDR_W   = CHIP8_ADDR_W,
    parameter int unsigned RESET_PC = CHIP8_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        hi_byte;
    logic              lo_pending;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              push;
    logic              issue_ok;
    int unsigned       occupancy;

    assign pop  = instr_valid && instr_ready;
    assign push = lo_pending && !redirect;

    // Occupancy also counts the instruction sitting in LO: it is decided on
    // in the LO cycle but only lands in the FIFO two edges later, and
    // without it back-to-back issue would overrun a full queue.
    always_comb begin
        occupancy = 32'(count) + 32'(lo_pending)
                  + ((state == ST_LO) ? 32'd1 : 32'd0)
                  - 32'(pop);
        issue_ok  = !halt && !redirect && (occupancy < DEPTH);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: state_next = issue_ok ? ST_HI : ST_IDLE;
            ST_HI:   state_next = redirect ? ST_IDLE : ST_LO;
            ST_LO:   state_next = issue_ok ? ST_HI : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: pc_q only advances when the pending low byte is pushed, so a
    // HI overlapping that push must already address the following pair.
    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        unique case (state)
            ST_HI: begin
                mem_rd   = 1'b1;
                mem_addr = lo_pending ? pc_q + ADDR_W'(2) : pc_q;
            end
            ST_LO: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q + ADDR_W'(1);
            end
            default: begin
                mem_rd   = 1'b0;
                mem_addr = '0;
            end
        endcase
    end

    // Fetch datapath: high-byte latch, low-byte pending flag, fetch pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= ADDR_W'(RESET_PC);
            hi_byte    <= '0;
            lo_pending <= 1'b0;
        end else if (redirect) begin
            pc_q       <= redirect_pc;
            hi_byte    <= '0;
            lo_pending <= 1'b0;
        end else begin
            lo_pending <= (state == ST_LO);
            if (state == ST_LO) begin
                hi_byte <= mem_data;
            end
            if (lo_pending) begin
                pc_q <= pc_q + ADDR_W'(2);
            end
        end
    end

    assign fetch_pc = pc_q;

    chip8_instr_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_instr ({hi_byte, mem_data}),
        .push_pc    (pc_q),
        .pop        (pop),
        .count      (count),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .head_valid (instr_valid)
    );

endmodule

// File: tb/tb_chip8_fetch.sv
// tb_chip8_fetch: directed scenarios plus randomized traffic for chip8_fetch.
// The reference model is an instruction-stream scoreboard: every accepted
// instruction must be the next one in program order from the last reset or
// redirect target, with its opcode read straight from the RAM image.
module tb_chip8_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        halt;
    logic [11:0] fetch_pc;

    logic [7:0]  ram [4096];

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [11:0] exp_pc;
    logic [11:0] last_pop_pc;

    always #5 clk = ~clk;

    chip8_fetch #(
        .ADDR_W   (12),
        .RESET_PC ('h100),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fetch_pc    (fetch_pc)
    );

    // Synchronous RAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [11:0] pc);
        logic [11:0] nxt;
        nxt = pc + 12'd1;
        return {ram[pc], ram[nxt]};
    endfunction

    // Score the handshake of the current cycle, then advance one clock.
    task automatic tick();
        if (rst_n && instr_valid && instr_ready) begin
            check_eq("pop_pc", 32'(instr_pc), 32'(exp_pc));
            check_eq("pop_instr", 32'(instr), 32'(ref_op(exp_pc)));
            last_pop_pc = exp_pc;
            exp_pc      = exp_pc + 12'd2;
            pops++;
        end
        if (rst_n && redirect) exp_pc = redirect_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input bit want_lo, output bit found);
        logic [11:0] lo_addr;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            lo_addr = fetch_pc + 12'd1;
            if (mem_rd && ((mem_addr == lo_addr) == want_lo)) found = 1'b1;
            else tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit          found;
        int          p0;
        int          rd_seen;
        logic [15:0] held;
        logic [11:0] haddr;
        logic [11:0] tmp;

        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram['h100] = 8'h12;
        ram['h101] = 8'h34;

        rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; halt = 1'b0; exp_pc = 12'h100; last_pop_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_rd",   32'(mem_rd), 32'h0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_valid",    32'(instr_valid), 32'h0);
        check_eq("rst_instr",    32'(instr), 32'h0);
        check_eq("rst_instr_pc", 32'(instr_pc), 32'h0);
        check_eq("rst_fetch_pc", 32'(fetch_pc), 32'h100);

        // 1: first fetch after reset
        instr_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        check_eq("t1_hi_rd",   32'(mem_rd), 32'h1);
        check_eq("t1_hi_addr", 32'(mem_addr), 32'h100);
        tick();
        check_eq("t1_lo_rd",   32'(mem_rd), 32'h1);
        check_eq("t1_lo_addr", 32'(mem_addr), 32'h101);
        tick();
        check_eq("t1_no_bypass", 32'(instr_valid), 32'h0);
        tick();
        check_eq("t1_valid",    32'(instr_valid), 32'h1);
        check_eq("t1_instr",    32'(instr), 32'h1234);
        check_eq("t1_instr_pc", 32'(instr_pc), 32'h100);

        // 2: sequential stream, one instruction per two cycles
        p0 = pops;
        repeat (16) tick();
        check_eq("t2_rate", 32'(pops - p0), 32'd8);

        // 3: backpressure from a fresh reset
        instr_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pc = 12'h100;
        repeat (14) tick();
        check_eq("t3_valid",    32'(instr_valid), 32'h1);
        check_eq("t3_head_pc",  32'(instr_pc), 32'h100);
        check_eq("t3_head_op",  32'(instr), 32'h1234);
        held = instr;
        rd_seen = 0;
        repeat (6) begin
            tick();
            if (mem_rd) rd_seen++;
            check_eq("t3_hold", 32'(instr), 32'(held));
        end
        check_eq("t3_full_idle", 32'(rd_seen), 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t3_next_head", 32'(instr_pc), 32'h102);
        check_eq("t3_resume_rd", 32'(mem_rd), 32'h1);
        check_eq("t3_resume_hi", 32'(mem_addr), 32'h104);
        tick();
        check_eq("t3_resume_lo", 32'(mem_addr), 32'h105);
        rd_seen = 0;
        repeat (8) begin
            tick();
            if (mem_rd) rd_seen++;
        end
        check_eq("t3_one_pair", 32'(rd_seen), 32'd0);
        check_eq("t3_head_kept", 32'(instr_pc), 32'h102);

        // 4: redirect while in LO
        instr_ready = 1'b1;
        wait_phase(1'b1, found);
        check_eq("t4_find_lo", 32'(found), 32'h1);
        redirect = 1'b1;
        redirect_pc = 12'h300;
        tick();
        redirect = 1'b0;
        check_eq("t4_fetch_pc", 32'(fetch_pc), 32'h300);
        check_eq("t4_flushed",  32'(instr_valid), 32'h0);
        check_eq("t4_idle",     32'(mem_rd), 32'h0);
        tick();
        check_eq("t4_hi_addr", 32'(mem_addr), 32'h300);
        p0 = pops;
        repeat (6) tick();
        check_eq("t4_popped", 32'(pops > p0), 32'h1);

        // 5: wrap-around with odd alignment
        redirect = 1'b1;
        redirect_pc = 12'hFFF;
        tick();
        redirect = 1'b0;
        tick();
        check_eq("t5_hi_addr", 32'(mem_addr), 32'hFFF);
        tick();
        check_eq("t5_lo_addr", 32'(mem_addr), 32'h000);
        p0 = pops;
        repeat (8) tick();
        check_eq("t5_two_pops", 32'(pops - p0 >= 2), 32'h1);

        // 6: halt during HI lets that instruction finish, nothing more
        wait_phase(1'b0, found);
        check_eq("t6_find_hi", 32'(found), 32'h1);
        haddr = mem_addr;
        halt = 1'b1;
        tick();
        tmp = haddr + 12'd1;
        check_eq("t6_lo_addr", 32'(mem_addr), 32'(tmp));
        rd_seen = 0;
        repeat (8) begin
            tick();
            if (mem_rd) rd_seen++;
        end
        check_eq("t6_halt_idle", 32'(rd_seen), 32'd0);
        check_eq("t6_completed", 32'(last_pop_pc), 32'(haddr));

        // 6b: reset mid-LO
        halt = 1'b0;
        wait_phase(1'b1, found);
        check_eq("t6_find_lo", 32'(found), 32'h1);
        rst_n = 1'b0;
        #2;
        check_eq("t6_rst_valid", 32'(instr_valid), 32'h0);
        check_eq("t6_rst_rd",    32'(mem_rd), 32'h0);
        check_eq("t6_rst_pc",    32'(fetch_pc), 32'h100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pc = 12'h100;
        tick();
        check_eq("t6_restart", 32'(mem_addr), 32'h100);

        // Randomized traffic
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            halt        = ($urandom_range(0, 15) == 0);
            redirect    = ($urandom_range(0, 31) == 0);
            redirect_pc = 12'($urandom);
            tick();
        end
        instr_ready = 1'b1; halt = 1'b0; redirect = 1'b0;
        repeat (10) tick();
        check_eq("rand_progress", 32'(pops - p0 > 200), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
